// File: rtl/prio_rr_arbiter_pkg.sv
// Shared types and helpers for the priority / round-robin arbiter.
package arb_pkg;

  localparam int unsigned MAX_N     = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // One-hot (or zero) vector to bit index; zero input yields index 0.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_rr_arbiter_pick.sv
// Combinational pick: first set bit of (req & mask), scanning upward from
// start in round-robin mode or from bit 0 in fixed mode, wrapping modulo N.
module arb_pick
  import arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] start,
  input  arb_mode_e       mode,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [N-1:0]    cand;
  logic [ID_W-1:0] start_eff;

  assign cand      = req & mask;
  assign start_eff = (mode == ARB_RR) ? start : '0;

  // Rotating priority scan; first hit wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && cand[(32'(start_eff) + i) % N]) begin
        any  = 1'b1;
        idx  = ID_W'((32'(start_eff) + i) % N);
        pick[(32'(start_eff) + i) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_rr_arbiter.sv
// N-way arbiter with registered one-hot grant, fixed or round-robin policy,
// grant locking while the owner keeps requesting, and a bounded hold time.
module prio_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N        = 4,
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  localparam int unsigned CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]    pick_mask;
  logic [N-1:0]    pick_gnt;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            arb_en;
  logic            owner_req;
  logic            others_req;
  logic            hold_expired;

  arb_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (ptr_q),
    .mode  (arb_mode_e'(mode)),
    .pick  (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign owner_req    = |(req & gnt_q);
  assign others_req   = |(req & ~gnt_q);
  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == CNT_W'(HOLD_LAST));

  // Next-state: hold, re-arbitrate on drop, or preempt on hold expiry.
  // Owner drop takes precedence over expiry, so the mask is only applied
  // when the owner is still requesting.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pick_mask = '1;
    arb_en    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|req) arb_en = 1'b1;
      end
      ARB_BUSY: begin
        if (!owner_req) begin
          arb_en = 1'b1;
        end else if (hold_expired) begin
          if (others_req) begin
            pick_mask = ~gnt_q;
            arb_en    = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (arb_en) begin
      cnt_d = '0;
      if (pick_any) begin
        state_d = ARB_BUSY;
        gnt_d   = pick_gnt;
        ptr_d   = ID_W'((32'(pick_idx) + 1) % N);
      end else begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    end

    gnt_id_d = ID_W'(onehot_to_idx(MAX_N'(gnt_d)));
  end

  // State and grant registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;

  // Simulation-only sanity checks on inputs and grant shape.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!$isunknown(req)) else $error("prio_rr_arbiter: X on req");
      assert ($onehot0(gnt_q)) else $error("prio_rr_arbiter: grant not one-hot");
    end
  end

endmodule

// File: doc/prio_rr_arbiter.md
# prio_rr_arbiter

Parametrised N-way request arbiter with a registered one-hot grant, runtime-selectable fixed-priority or round-robin policy, and grant locking with bounded hold time. It sits in front of any shared resource such as a bus, memory port or output channel. It is the scalable successor to the team's 4-input fixed-priority arbiter. A granted requester keeps ownership while its request stays high, subject to a starvation limit.

## Interface
- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 8: maximum consecutive grant cycles before forced re-arbitration when others are waiting; 0 = unlimited.
- ID_W, default $clog2(N): width of gnt_id (derived, not overridden).
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low.
- req, input, N: request vector; bit i = requester i.
- mode, input, 1: 0 = fixed priority (bit 0 highest), 1 = round-robin; sampled only at arbitration.
- gnt, output, N: registered one-hot grant; all zero when idle.
- gnt_id, output, ID_W: index of the granted requester; 0 when idle.
- gnt_valid, output, 1: high when any grant bit is set.

## Operation
- State machine has two states.
  - IDLE: no owner.
  - BUSY: owner = gnt_id, hold counter cnt runs.
- Arbitration is a combinational pick over a candidate mask; its result is registered on the next clk edge.
  - Fixed mode: lowest-index set bit wins.
  - RR mode: search starts at ptr and wraps modulo N; first set bit wins.
- ptr:
  - Resets to 0.
  - On every new grant to index k, ptr <= (k+1) mod N, in both modes.
- IDLE → BUSY when req != 0. gnt = pick(req), cnt = 0.
- BUSY, owner request still high, cnt < MAX_HOLD-1 (or MAX_HOLD = 0): hold the grant, cnt increments.
- BUSY, owner request dropped:
  - Re-arbitrate on req in the same cycle; the new grant appears on the next edge with no idle bubble.
  - If req = 0, go to IDLE: gnt = 0, gnt_valid = 0, gnt_id = 0.
- BUSY, cnt = MAX_HOLD-1, owner still requesting:
  - Other requests pending: pick over req with the owner bit masked off; the owner is preempted and cnt = 0.
  - No other request: owner keeps the grant and cnt restarts at 0.
- Never more than one gnt bit high.
- gnt_id always encodes gnt.
- Request bits that are X are treated as an error in simulation only (assertion).

## Timing
- Reset (asynchronous, immediate, also mid-operation) sets gnt = 0, gnt_id = 0, gnt_valid = 0, state = IDLE, ptr = 0, cnt = 0. The first grant is possible on the first edge after reset deasserts.
- Latency: req rising while IDLE → gnt on the next rising edge (1 cycle).
- Owner drops req in cycle t → the new owner's grant is visible after edge t+1. Old grant and new grant never overlap.
- Hold limit: with MAX_HOLD = M, an owner holds at most M consecutive cycles while others wait.
- Mode change takes effect at the next arbitration event only. It never revokes a held grant.
- Simultaneous owner drop and hold-limit expiry: treat as an owner drop, with no mask applied.
- Worst-case wait in RR mode is (N-1)·M cycles. Fixed mode gives no starvation guarantee beyond preemption.

## Structure
- Shared package arb_pkg holds:
  - arb_mode_e enum: ARB_FIXED = 1'b0, ARB_RR = 1'b1.
  - arb_state_e enum: ARB_IDLE, ARB_BUSY.
  - Helper function for the one-hot → index encode.
- One sub-module, arb_pick, is natural:
  - Purely combinational.
  - Inputs: req, mask, start pointer, mode.
  - Outputs: one-hot pick, index, any.
  - Instantiated once.
- All state lives in the top level: state register, ptr, cnt, grant registers.

## Test plan
Setup: N = 4, MAX_HOLD = 4.
- Reset mid-grant: owner 2 active, pull reset low between edges → gnt = 0000, gnt_valid = 0 immediately. After release, req = 0100 → gnt = 0100 one edge later.
- Fixed mode, req = 1110 held, each owner drops after 2 cycles → grant order 0010, 0100, 1000. No bubble between owners.
- RR mode, req = 1111 constant → each owner preempted after 4 cycles. Order 0001, 0010, 0100, 1000, 0001; gnt_id 0, 1, 2, 3, 0.
- Hold limit with a single requester: req = 0100 for 12 cycles → gnt = 0100 continuously, never deasserted.
- Mode switch: owner 0 held in fixed mode, set mode = 1 mid-hold → grant unchanged until the owner drops or is preempted. Next pick starts from ptr = 1.
- Simultaneous drop and expiry: owner 1 drops req exactly at cnt = 3 with req = 0011 → next owner is 0, with no mask applied.
